// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// Holds predecoded conditional branches from fetch, in program order, until
// execute resolves them. Each resolution is compared with the static
// prediction made at push time. A wrong guess produces a registered one-cycle
// redirect to the correct PC and discards every younger (wrong-path) entry.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [XLEN-1:0]  push_pc,
    input  logic [XLEN-1:0]  push_imm,
    output logic             push_ready,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [XLEN-1:0]  res_target,
    input  logic             flush_in,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             empty,
    output logic             full,
    output logic             underflow_err,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [XLEN-1:0]  pc_mem     [DEPTH];
    logic             taken_mem  [DEPTH];
    logic [XLEN-1:0]  target_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic             do_pop;
    logic             do_push;
    logic             mispredict;
    logic             clear_q;
    logic [XLEN-1:0]  head_pc;
    logic             head_taken;
    logic [XLEN-1:0]  head_target;
    logic [XLEN-1:0]  correct_pc;

    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign push_ready  = !full;
    assign pred_taken  = push_imm[XLEN-1];
    assign pred_target = push_pc + push_imm;

    // Resolve the head entry: detect a mispredict, pick the correct next PC and
    // decide whether this cycle's push survives (it is wrong-path on a clear).
    always_comb begin
        head_pc     = pc_mem[rd_ptr];
        head_taken  = taken_mem[rd_ptr];
        head_target = target_mem[rd_ptr];
        do_pop      = res_valid && !empty;
        mispredict  = 1'b0;
        if (do_pop) begin
            mispredict = (res_taken != head_taken) ||
                         (res_taken && (res_target != head_target));
        end
        correct_pc  = res_taken ? res_target : head_pc + XLEN'(4);
        clear_q     = flush_in || mispredict;
        do_push     = push_valid && !full && !clear_q;
    end

    // Entry storage carries no reset; only slots between the pointers are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]     <= push_pc;
            taken_mem[wr_ptr]  <= pred_taken;
            target_mem[wr_ptr] <= pred_target;
        end
    end

    // Pointer and occupancy bookkeeping; a clear drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_q) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // One-cycle redirect on a mispredict, suppressed when an external flush wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= mispredict && !flush_in;
            if (mispredict && !flush_in) begin
                redirect_pc <= correct_pc;
            end
        end
    end

    // Sticky underflow flag and saturating mispredict statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_err    <= 1'b0;
            mispredict_count <= '0;
        end else begin
            if (res_valid && empty) begin
                underflow_err <= 1'b1;
            end
            if (mispredict && (mispredict_count != {CNT_W{1'b1}})) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule
